// File: rtl/registered_channel_mux.sv
// Registered N-way channel selector with direct/auto-scan modes, hold,
// strobe-forced zero capture and out-of-range select detection.
module registered_channel_mux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2
) (
  input  logic                         CLK,
  input  logic                         CLR,
  input  logic [CHANNELS*WIDTH-1:0]    D,
  input  logic [$clog2(CHANNELS)-1:0]  SELECT,
  input  logic                         MODE,
  input  logic                         G_bar,
  input  logic                         HOLD,
  output logic [WIDTH-1:0]             Q,
  output logic [$clog2(CHANNELS)-1:0]  CH,
  output logic                         WRAP,
  output logic                         ERR
);

  localparam int SEL_W = $clog2(CHANNELS);
  localparam logic [SEL_W:0]   CH_COUNT = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] cnt;
  logic [SEL_W-1:0] idx;
  logic [WIDTH-1:0] sel_word;
  logic             in_range;

  assign idx      = MODE ? cnt : SELECT;
  assign in_range = ({1'b0, SELECT} < CH_COUNT);

  // Explicit compare-per-channel keeps the mux in bounds when SELECT
  // exceeds CHANNELS-1 (non-power-of-two channel counts).
  always_comb begin
    sel_word = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (idx == SEL_W'(k)) sel_word = D[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR || G_bar) begin
      Q    <= '0;
      CH   <= '0;
      cnt  <= '0;
      WRAP <= 1'b0;
      ERR  <= 1'b0;
    end else if (HOLD) begin
      WRAP <= 1'b0;
    end else if (MODE) begin
      Q   <= sel_word;
      CH  <= cnt;
      ERR <= 1'b0;
      if (cnt == LAST_CH) begin
        cnt  <= '0;
        WRAP <= 1'b1;
      end else begin
        cnt  <= cnt + SEL_W'(1);
        WRAP <= 1'b0;
      end
    end else begin
      Q    <= in_range ? sel_word : '0;
      CH   <= SELECT;
      ERR  <= ~in_range;
      cnt  <= '0;
      WRAP <= 1'b0;
    end
  end

endmodule
